// File: rtl/irq_trap_ctrl_pkg.sv
// Shared constants and state type for the machine-mode trap entry / mret sequencer.
// CSR addresses, interrupt cause codes and mstatus field positions live here.
package irq_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MEPC   = 3'd1,
    S_MCAUSE = 3'd2,
    S_MSTAT  = 3'd3,
    S_MRET   = 3'd4
  } state_t;

endpackage

// File: rtl/irq_trap_ctrl_if.sv
// Bundle of CLINT/pipeline inputs and CSR-write/redirect outputs of irq_trap_ctrl.
// master = pipeline/CSR side, slave = the sequencer.
interface irq_trap_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  timer_irq_i;
  logic                  software_irq_i;
  logic                  external_irq_i;
  logic                  inst_valid_i;
  logic [DATA_WIDTH-1:0] inst_pc_i;
  logic                  mret_i;
  logic [DATA_WIDTH-1:0] mstatus_i;
  logic [DATA_WIDTH-1:0] mie_i;
  logic [DATA_WIDTH-1:0] mtvec_i;
  logic [DATA_WIDTH-1:0] mepc_i;
  logic [DATA_WIDTH-1:0] mip_o;
  logic                  stall_o;
  logic                  csr_we_o;
  logic [11:0]           csr_waddr_o;
  logic [DATA_WIDTH-1:0] csr_wdata_o;
  logic                  jump_flag_o;
  logic [DATA_WIDTH-1:0] jump_addr_o;

  modport master (
    output timer_irq_i, software_irq_i, external_irq_i, inst_valid_i, inst_pc_i,
           mret_i, mstatus_i, mie_i, mtvec_i, mepc_i,
    input  mip_o, stall_o, csr_we_o, csr_waddr_o, csr_wdata_o, jump_flag_o, jump_addr_o
  );

  modport slave (
    input  timer_irq_i, software_irq_i, external_irq_i, inst_valid_i, inst_pc_i,
           mret_i, mstatus_i, mie_i, mtvec_i, mepc_i,
    output mip_o, stall_o, csr_we_o, csr_waddr_o, csr_wdata_o, jump_flag_o, jump_addr_o
  );
endinterface

// File: rtl/irq_trap_ctrl_prio_enc.sv
// Fixed-priority encoder over enabled pending interrupts: MEI > MSI > MTI.
// i_pend is {meip, mtip, msip} already masked by mie.
module irq_trap_ctrl_prio_enc
  import irq_trap_ctrl_pkg::*;
(
  input  logic [2:0] i_pend,
  output logic       o_valid,
  output logic [3:0] o_code
);

  always_comb begin
    o_valid = |i_pend;
    o_code  = '0;
    if (i_pend[2]) begin
      o_code = IRQ_MEI;
    end else if (i_pend[0]) begin
      o_code = IRQ_MSI;
    end else if (i_pend[1]) begin
      o_code = IRQ_MTI;
    end
  end

endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt entry and mret sequencer: samples IRQs into mip, stalls the
// pipeline, writes mepc/mcause/mstatus over one CSR port, then redirects the PC.
//
// state    | meaning
// S_IDLE   | waiting for a retire boundary with a takeable IRQ or an MRET
// S_MEPC   | writing latched PC to mepc
// S_MCAUSE | writing latched cause to mcause
// S_MSTAT  | stacking MIE into mstatus, jumping to the trap vector
// S_MRET   | restoring MIE from MPIE, jumping to mepc
module irq_trap_ctrl
  import irq_trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input logic            clk_i,
  input logic            rst_i,
  irq_trap_ctrl_if.slave bus
);

  state_t                r_state, w_next;
  logic [2:0]            r_pend;
  logic [DATA_WIDTH-1:0] r_epc;
  logic [3:0]            r_code;

  logic [2:0]            w_enabled;
  logic                  w_irq_valid, w_take, w_mret, w_latch;
  logic [3:0]            w_irq_code;
  logic                  w_stall, w_we, w_jump;
  logic [11:0]           w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata, w_jaddr, w_mip, w_cause;
  logic [DATA_WIDTH-1:0] w_base, w_off, w_target, w_mstat_trap, w_mstat_mret;

  assign w_enabled = r_pend & {bus.mie_i[IRQ_MEI], bus.mie_i[IRQ_MTI], bus.mie_i[IRQ_MSI]};

  irq_trap_ctrl_prio_enc u_prio (
    .i_pend  (w_enabled),
    .o_valid (w_irq_valid),
    .o_code  (w_irq_code)
  );

  assign w_take = (r_state == S_IDLE) && bus.inst_valid_i &&
                  bus.mstatus_i[MSTATUS_MIE] && w_irq_valid;
  assign w_mret = bus.inst_valid_i && bus.mret_i;

  always_comb begin
    w_mip                = '0;
    w_mip[IRQ_MSI]       = r_pend[0];
    w_mip[IRQ_MTI]       = r_pend[1];
    w_mip[IRQ_MEI]       = r_pend[2];
    w_cause              = '0;
    w_cause[DATA_WIDTH-1] = 1'b1;
    w_cause[3:0]         = r_code;
    w_base               = {bus.mtvec_i[DATA_WIDTH-1:2], 2'b00};
    w_off                = '0;
    w_off[5:2]           = r_code;
    // vector offset wraps modulo 2^DATA_WIDTH by construction
    w_target = (VECTORED_EN && bus.mtvec_i[1:0] == 2'b01) ? w_base + w_off : w_base;
    w_mstat_trap                                 = bus.mstatus_i;
    w_mstat_trap[MSTATUS_MPIE]                   = bus.mstatus_i[MSTATUS_MIE];
    w_mstat_trap[MSTATUS_MIE]                    = 1'b0;
    w_mstat_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    w_mstat_mret                                 = bus.mstatus_i;
    w_mstat_mret[MSTATUS_MIE]                    = bus.mstatus_i[MSTATUS_MPIE];
    w_mstat_mret[MSTATUS_MPIE]                   = 1'b1;
    w_mstat_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    w_jump  = 1'b0;
    w_jaddr = '0;
    w_latch = 1'b0;
    case (r_state)
      S_IDLE: begin
        // an interrupt beats a simultaneous mret; the mret re-executes after the handler
        if (w_take) begin
          w_stall = 1'b1;
          w_latch = 1'b1;
          w_next  = S_MEPC;
        end else if (w_mret) begin
          w_stall = 1'b1;
          w_next  = S_MRET;
        end
      end
      S_MEPC: begin
        w_stall = 1'b1;
        w_we    = 1'b1;
        w_waddr = CSR_MEPC;
        w_wdata = r_epc;
        w_next  = S_MCAUSE;
      end
      S_MCAUSE: begin
        w_stall = 1'b1;
        w_we    = 1'b1;
        w_waddr = CSR_MCAUSE;
        w_wdata = w_cause;
        w_next  = S_MSTAT;
      end
      S_MSTAT: begin
        w_stall = 1'b1;
        w_we    = 1'b1;
        w_waddr = CSR_MSTATUS;
        w_wdata = w_mstat_trap;
        w_jump  = 1'b1;
        w_jaddr = w_target;
        w_next  = S_IDLE;
      end
      S_MRET: begin
        w_stall = 1'b1;
        w_we    = 1'b1;
        w_waddr = CSR_MSTATUS;
        w_wdata = w_mstat_mret;
        w_jump  = 1'b1;
        w_jaddr = bus.mepc_i;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pend <= '0;
      r_epc  <= '0;
      r_code <= '0;
    end else begin
      r_pend <= {bus.external_irq_i, bus.timer_irq_i, bus.software_irq_i};
      if (w_latch) begin
        r_epc  <= bus.inst_pc_i;
        r_code <= w_irq_code;
      end
    end
  end

  assign bus.mip_o       = w_mip;
  assign bus.stall_o     = w_stall;
  assign bus.csr_we_o    = w_we;
  assign bus.csr_waddr_o = w_waddr;
  assign bus.csr_wdata_o = w_wdata;
  assign bus.jump_flag_o = w_jump;
  assign bus.jump_addr_o = w_jaddr;

endmodule
